// File: rtl/inst_fetcher.sv
// Instruction fetch front-end: static branch prediction, single outstanding memory request,
// and an issue queue feeding the decoder. Define ICACHE_EN to add a direct-mapped i-cache.
module inst_fetcher #(
  parameter int unsigned IQ_DEPTH     = 8,
  parameter int unsigned IQ_PTR_W     = 3,
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_stall,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_jump_flag,
  output logic        out_mc_req,
  output logic [31:0] out_mc_addr,
  input  logic        in_mc_done,
  input  logic [31:0] in_mc_inst,
  input  logic        in_rob_flush,
  input  logic [31:0] in_rob_target_pc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;
  localparam int unsigned CNT_W = IQ_PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IQ_DEPTH);

  if (IQ_DEPTH != (32'd1 << IQ_PTR_W)) begin : g_bad_depth
    $error("IQ_DEPTH must equal 2**IQ_PTR_W");
  end
  if ((ICACHE_LINES & (ICACHE_LINES - 32'd1)) != 32'd0) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two");
  end

  function automatic logic predict_taken(input logic [31:0] inst);
    predict_taken = (inst[6:0] == 7'b1101111) || ((inst[6:0] == 7'b1100011) && inst[31]);
  endfunction

  function automatic logic [31:0] predict_next(input logic [31:0] inst, input logic [31:0] pc);
    logic [31:0] imm;
    if (inst[6:0] == 7'b1101111) begin
      imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    end else if ((inst[6:0] == 7'b1100011) && inst[31]) begin
      imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    end else begin
      imm = 32'd4;
    end
    predict_next = pc + imm;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic                mc_req_q, mc_req_d;
  logic [31:0]         mc_addr_q, mc_addr_d;
  logic [IQ_PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [31:0]         out_inst_q, out_inst_d, out_pc_q, out_pc_d;
  logic                out_jf_q, out_jf_d;

  logic [31:0] iq_inst_q [IQ_DEPTH];
  logic [31:0] iq_pc_q   [IQ_DEPTH];
  logic        iq_jf_q   [IQ_DEPTH];

  logic        enq_s, deq_s, not_full_s;
  logic [31:0] enq_inst_s;

  assign not_full_s = (count_q < CNT_FULL);

`ifdef ICACHE_EN
  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  logic [ICACHE_LINES-1:0] ic_valid_q;
  logic [31:IDX_W+2]       ic_tag_q  [ICACHE_LINES];
  logic [31:0]             ic_data_q [ICACHE_LINES];
  logic [IDX_W-1:0]        ic_idx_s;
  logic                    ic_hit_s, ic_fill_s;

  assign ic_idx_s  = pc_q[IDX_W+1:2];
  assign ic_hit_s  = ic_valid_q[ic_idx_s] && (ic_tag_q[ic_idx_s] == pc_q[31:IDX_W+2]);
  assign ic_fill_s = (state_q == WAIT) && in_mc_done && !in_rob_flush;
`endif

  // Fetch FSM and PC selection; flush overrides the PC and kills any enqueue.
  always_comb begin
    state_d    = state_q;
    mc_req_d   = mc_req_q;
    mc_addr_d  = mc_addr_q;
    enq_s      = 1'b0;
    enq_inst_s = in_mc_inst;
    case (state_q)
      IDLE: begin
        mc_req_d = 1'b0;
        if (in_rob_flush) begin
          state_d = IDLE;
`ifdef ICACHE_EN
        end else if (not_full_s && ic_hit_s) begin
          enq_s      = 1'b1;
          enq_inst_s = ic_data_q[ic_idx_s];
`endif
        end else if (not_full_s) begin
          mc_req_d  = 1'b1;
          mc_addr_d = pc_q;
          state_d   = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (in_mc_done) begin
          mc_req_d = 1'b0;
          state_d  = IDLE;
          enq_s    = !in_rob_flush;
        end else if (in_rob_flush) begin
          mc_req_d = 1'b0;
          state_d  = DROP;
        end else begin
          mc_req_d = 1'b1;
        end
      end
      DROP: begin
        mc_req_d = 1'b0;
        if (in_mc_done) begin
          state_d = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        mc_req_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    if (in_rob_flush) begin
      pc_d = in_rob_target_pc;
    end else if (enq_s) begin
      pc_d = predict_next(enq_inst_s, pc_q);
    end else begin
      pc_d = pc_q;
    end
  end

  // Queue pointers and the registered issue slot.
  always_comb begin
    deq_s = (count_q != {CNT_W{1'b0}}) && !in_stall && !in_rob_flush;
    if (in_rob_flush) begin
      head_d  = {IQ_PTR_W{1'b0}};
      tail_d  = {IQ_PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      head_d  = head_q + IQ_PTR_W'(deq_s);
      tail_d  = tail_q + IQ_PTR_W'(enq_s);
      count_d = count_q + CNT_W'(enq_s) - CNT_W'(deq_s);
    end
    if (deq_s) begin
      out_inst_d = iq_inst_q[head_q];
      out_pc_d   = iq_pc_q[head_q];
      out_jf_d   = iq_jf_q[head_q];
    end else begin
      out_inst_d = 32'h0;
      out_pc_d   = 32'h0;
      out_jf_d   = 1'b0;
    end
  end

  // Control and output registers; rdy low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      mc_req_q   <= 1'b0;
      mc_addr_q  <= 32'h0;
      head_q     <= {IQ_PTR_W{1'b0}};
      tail_q     <= {IQ_PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      out_inst_q <= 32'h0;
      out_pc_q   <= 32'h0;
      out_jf_q   <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mc_req_q   <= mc_req_d;
      mc_addr_q  <= mc_addr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      out_inst_q <= out_inst_d;
      out_pc_q   <= out_pc_d;
      out_jf_q   <= out_jf_d;
    end
  end

  // Queue storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk) begin
    if (rdy && enq_s) begin
      iq_inst_q[tail_q] <= enq_inst_s;
      iq_pc_q[tail_q]   <= pc_q;
      iq_jf_q[tail_q]   <= predict_taken(enq_inst_s);
    end
  end

`ifdef ICACHE_EN
  // Line valid bits survive flushes and are cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_valid_q <= {ICACHE_LINES{1'b0}};
    end else if (rdy && ic_fill_s) begin
      ic_valid_q[ic_idx_s] <= 1'b1;
    end
  end

  // Line fill from every memory response that is kept.
  always_ff @(posedge clk) begin
    if (rdy && ic_fill_s) begin
      ic_tag_q[ic_idx_s]  <= pc_q[31:IDX_W+2];
      ic_data_q[ic_idx_s] <= in_mc_inst;
    end
  end
`endif

  assign out_inst      = out_inst_q;
  assign out_pc        = out_pc_q;
  assign out_jump_flag = out_jf_q;
  assign out_mc_req    = mc_req_q;
  assign out_mc_addr   = mc_addr_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: memory-controller model plus a transaction-level fetch/issue model.
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        in_stall = 1'b0;
  logic [31:0] out_inst, out_pc, out_mc_addr;
  logic        out_jump_flag, out_mc_req;
  logic        in_mc_done = 1'b0;
  logic [31:0] in_mc_inst = 32'h0;
  logic        in_rob_flush = 1'b0;
  logic [31:0] in_rob_target_pc = 32'h0;

  inst_fetcher dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_stall(in_stall),
    .out_inst(out_inst), .out_pc(out_pc), .out_jump_flag(out_jump_flag),
    .out_mc_req(out_mc_req), .out_mc_addr(out_mc_addr),
    .in_mc_done(in_mc_done), .in_mc_inst(in_mc_inst),
    .in_rob_flush(in_rob_flush), .in_rob_target_pc(in_rob_target_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        jf;
  } ent_t;

  ent_t        m_q[$];
  ent_t        issued[$];
  logic [31:0] latched[$];
  logic [31:0] mem [logic [31:0]];

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] m_pc = 32'h0;
  bit          outstanding = 1'b0;
  bit          killed = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] exp_inst = 32'h0, exp_pc = 32'h0;
  logic        exp_jf = 1'b0;
  bit          mem_rand = 1'b0, rand_mode = 1'b0, stall_force = 1'b0;
  int          lat_fix = 3;
  bit          flush_req = 1'b0, flush_need_wait = 1'b0;
  logic [31:0] flush_req_tgt = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic m_taken(input logic [31:0] i);
    return (i[6:0] == 7'b1101111) || (i[6:0] == 7'b1100011 && i[31] == 1'b1);
  endfunction

  // Offsets assembled unsigned, then the sign weight is subtracted.
  function automatic logic [31:0] m_target(input logic [31:0] i, input logic [31:0] pc);
    logic [31:0] off;
    if (i[6:0] == 7'b1101111) begin
      off = {11'h0, i[31], i[19:12], i[20], i[30:21], 1'b0};
      if (i[31]) off = off - 32'h0020_0000;
    end else if (i[6:0] == 7'b1100011 && i[31] == 1'b1) begin
      off = {19'h0, i[31], i[7], i[30:25], i[11:8], 1'b0};
      off = off - 32'h0000_2000;
    end else begin
      off = 32'd4;
    end
    return pc + off;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    int unsigned k;
    if (mem.exists(a)) return mem[a];
    if (mem_rand) begin
      k = $urandom_range(0, 3);
      w = $urandom;
      case (k)
        0: w[6:0] = 7'b0010011;
        1: w[6:0] = 7'b1101111;
        2: w[6:0] = 7'b1100011;
        default: w[6:0] = 7'b1100111;
      endcase
    end else begin
      w = 32'h0000_0013;
    end
    mem[a] = w;
    return w;
  endfunction

  // One clock: update the model for the edge just passed, compare, then drive the next inputs.
  task automatic step();
    ent_t e, ne;
    logic n_rdy, n_done, n_flush, n_stall;
    logic [31:0] n_inst, n_tgt;
    @(negedge clk);
    if (rdy) begin
      if (m_q.size() > 0 && !in_stall && !in_rob_flush) begin
        e = m_q.pop_front();
        issued.push_back(e);
      end else begin
        e.inst = 32'h0; e.pc = 32'h0; e.jf = 1'b0;
      end
      exp_inst = e.inst; exp_pc = e.pc; exp_jf = e.jf;
      if (in_mc_done) begin
        if (!in_rob_flush && !killed) begin
          ne.inst = in_mc_inst; ne.pc = m_pc; ne.jf = m_taken(in_mc_inst);
          m_q.push_back(ne);
          m_pc = m_target(in_mc_inst, m_pc);
        end
        outstanding = 1'b0;
        killed = 1'b0;
      end
      if (in_rob_flush) begin
        m_q.delete();
        m_pc = in_rob_target_pc;
        if (outstanding) killed = 1'b1;
      end
    end
    chk("out_inst", out_inst, exp_inst);
    chk("out_pc", out_pc, exp_pc);
    chk("out_jump_flag", {31'h0, out_jump_flag}, {31'h0, exp_jf});
    if (killed || (rdy && in_mc_done)) chk("req_low", {31'h0, out_mc_req}, 32'h0);

    n_rdy = rand_mode ? ($urandom_range(0, 9) != 0) : 1'b1;
    n_done = 1'b0; n_inst = 32'h0; n_flush = 1'b0; n_tgt = 32'h0;
    if (n_rdy) begin
      if (out_mc_req && !outstanding) begin
        chk("fetch_addr", out_mc_addr, m_pc);
        chk("iq_room", {31'h0, m_q.size() < 8}, 32'h1);
        latched.push_back(out_mc_addr);
        mem_addr = out_mc_addr;
        outstanding = 1'b1;
        mem_cnt = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
      end else if (outstanding && mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          n_done = 1'b1;
          n_inst = mem_word(mem_addr);
        end
      end
      if (flush_req && (!flush_need_wait || (outstanding && !killed && !n_done))) begin
        n_flush = 1'b1;
        n_tgt = flush_req_tgt;
        flush_req = 1'b0;
      end else if (rand_mode && $urandom_range(0, 39) == 0) begin
        n_flush = 1'b1;
        n_tgt = 32'($urandom_range(0, 1023)) << 2;
      end
    end
    n_stall = stall_force ? 1'b1 : (rand_mode ? ($urandom_range(0, 2) == 0) : 1'b0);
    rdy = n_rdy;
    in_mc_done = n_done;
    in_mc_inst = n_inst;
    in_rob_flush = n_flush;
    in_rob_target_pc = n_tgt;
    in_stall = n_stall;
  endtask

  task automatic run_until(input int nl, input int ni, input string what);
    int k = 0;
    while ((latched.size() < nl || issued.size() < ni) && k < 600) begin
      step();
      k++;
    end
    chk({what, "_timeout"}, {31'h0, (latched.size() >= nl && issued.size() >= ni)}, 32'h1);
  endtask

  task automatic wait_flush(input string what);
    int k = 0;
    while (flush_req && k < 200) begin
      step();
      k++;
    end
    chk({what, "_timeout"}, {31'h0, !flush_req}, 32'h1);
  endtask

  logic [31:0] exp_seq [11];
  int base;
  int found;

  initial begin
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h18, 32'h1C, 32'h20, 32'h1C, 32'h20, 32'h1C};
    mem[32'h10] = 32'h0080_006F;
    mem[32'h20] = 32'hFE00_0EE3;
    mem[32'h30] = 32'h0020_9463;

    repeat (3) @(negedge clk);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_jump_flag", {31'h0, out_jump_flag}, 32'h0);
    chk("rst_mc_req", {31'h0, out_mc_req}, 32'h0);
    chk("rst_mc_addr", out_mc_addr, 32'h0);
    rst = 1'b0;

    // Straight-line code, JAL and backward branch.
    run_until(11, 9, "seq");
    for (int i = 0; i < 11; i++) chk($sformatf("seq_addr%0d", i), latched[i], exp_seq[i]);
    chk("iss0_pc", issued[0].pc, 32'h0);
    chk("iss0_jf", {31'h0, issued[0].jf}, 32'h0);
    chk("jal_inst", issued[4].inst, 32'h0080_006F);
    chk("jal_pc", issued[4].pc, 32'h10);
    chk("jal_jf", {31'h0, issued[4].jf}, 32'h1);
    chk("jal_succ_pc", issued[5].pc, 32'h18);
    chk("beq_pc", issued[7].pc, 32'h20);
    chk("beq_jf", {31'h0, issued[7].jf}, 32'h1);
    chk("beq_succ_pc", issued[8].pc, 32'h1C);

    // Forward branch predicted not taken.
    flush_req = 1'b1; flush_req_tgt = 32'h30; flush_need_wait = 1'b0;
    wait_flush("bne_flush");
    base = latched.size();
    run_until(base + 2, 0, "bne");
    chk("bne_fetch", latched[base], 32'h30);
    chk("bne_next", latched[base + 1], 32'h34);
    repeat (10) step();
    found = 0;
    foreach (issued[i]) if (issued[i].pc == 32'h30) begin
      found = 1;
      chk("bne_jf", {31'h0, issued[i].jf}, 32'h0);
    end
    chk("bne_issued", found, 1);

    // Stall until the queue is full, then drain back-to-back.
    lat_fix = 1;
    stall_force = 1'b1;
    repeat (40) step();
    chk("stall_model_full", m_q.size(), 8);
    chk("stall_req", {31'h0, out_mc_req}, 32'h0);
    chk("stall_inst", out_inst, 32'h0);
    stall_force = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("burst%0d", i), {31'h0, out_inst != 32'h0}, 32'h1);
    end

    // Flush while a request is in flight.
    lat_fix = 4;
    flush_req = 1'b1; flush_req_tgt = 32'h100; flush_need_wait = 1'b1;
    wait_flush("wait_flush");
    step();
    chk("flush_dropping", {31'h0, killed}, 32'h1);
    chk("flush_req_low", {31'h0, out_mc_req}, 32'h0);
    chk("flush_issue_zero", out_inst, 32'h0);
    base = latched.size();
    run_until(base + 1, 0, "flush_refetch");
    chk("flush_refetch_addr", latched[base], 32'h100);

    // Randomized traffic.
    base = issued.size();
    mem_rand = 1'b1; rand_mode = 1'b1; lat_fix = 0;
    repeat (4000) step();
    chk("random_progress", {31'h0, (issued.size() - base) >= 300}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
Front-end stage directly upstream of the decoder. It fetches 32-bit instruction words from the memory controller and applies static branch prediction to choose the next PC. Fetched words are buffered in an instruction queue, and one {inst, pc, jump_flag} triple per cycle is issued to the decoder. On an ROB flush it discards all in-flight work and restarts at the corrected PC.

Parameters:
IQ_DEPTH, 8, instruction queue entries (power of two)
IQ_PTR_W, 3, log2(IQ_DEPTH)
RESET_PC, 32'h0, PC after reset
ICACHE_LINES, 16, direct-mapped i-cache lines (power of two); used only with ICACHE_EN

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rdy  in  1  global ready; low freezes all state
in_stall  in  1  downstream (ROB/RS/LSB) full; suppresses issue
out_inst  out  32  instruction to decoder; 32'h0 when nothing issued
out_pc  out  32  PC of out_inst
out_jump_flag  out  1  1 = out_inst was predicted taken
out_mc_req  out  1  fetch request, level, held until in_mc_done
out_mc_addr  out  32  word address of request
in_mc_done  in  1  one-cycle pulse: in_mc_inst valid
in_mc_inst  in  32  fetched instruction word
in_rob_flush  in  1  mispredict flush pulse
in_rob_target_pc  in  32  restart PC, valid with in_rob_flush

Behaviour:
- Reset (async, rst=1): pc=RESET_PC; queue empty, count=0; state=IDLE; out_inst=0, out_pc=0, out_jump_flag=0, out_mc_req=0, out_mc_addr=0.
- rdy=0: no register changes and outputs hold. The memory controller is gated by the same rdy, so no in_mc_done arrives while rdy=0.
- FSM states: IDLE, WAIT, DROP.
  - IDLE: if count < IQ_DEPTH and no flush, register out_mc_req=1, out_mc_addr=pc, then go to WAIT.
  - WAIT: out_mc_req stays high.
    - On in_mc_done: enqueue {in_mc_inst, pc, pred}, set pc = next_pc, drop out_mc_req, go to IDLE.
  - DROP: out_mc_req=0. On in_mc_done, discard the data and go to IDLE. The controller latches a request on its first high cycle, so it always completes once.
- Only one request is outstanding. Because the request is gated on count < IQ_DEPTH, the queue never overflows.
- Prediction, combinational on the fetched word:
  - JAL (opcode 1101111): pred=1, next_pc = pc + sign-extended J-immediate.
  - Branch (1100011) with inst[31]=1 (backward): pred=1, next_pc = pc + sign-extended B-immediate.
  - Everything else, including JALR: pred=0, next_pc = pc + 4.
  - All adds are 32-bit and wrap modulo 2^32.
- Issue (registered): when queue non-empty, in_stall=0 and no flush, pop the head into out_inst/out_pc/out_jump_flag. Otherwise drive all three to 0; the decoder ignores opcode 0.
- Latency: a word whose in_mc_done arrives at edge N is enqueued at N. It appears on out_inst after edge N+1 at the earliest. Fetch-to-fetch spacing is at least 1 cycle plus memory latency.
- Enqueue and dequeue in the same cycle: count is unchanged; pointers wrap modulo IQ_DEPTH.
- in_rob_flush (priority over everything):
  - Queue cleared, count=0, pc = in_rob_target_pc, issue outputs zeroed that cycle.
  - State WAIT without done → DROP.
  - State WAIT with simultaneous done → IDLE, data discarded.
  - State IDLE → IDLE, no request that cycle.
  - State DROP → DROP, or IDLE if done arrives that cycle.
- Reset asserted mid-request: immediate return to reset state. A late in_mc_done in IDLE is ignored.

Optional Feature:
ICACHE_EN: adds a direct-mapped i-cache of ICACHE_LINES one-word lines (valid, tag, data), indexed by pc[log2(ICACHE_LINES)+1:2].
- With the macro: in IDLE, a hit enqueues directly that cycle with no memory request. Every in_mc_done that is not discarded fills the line. Flush does not invalidate; reset clears all valid bits.
- Without the macro: every fetch goes to memory, and no cache storage is synthesised.

Test Plan:
- Reset, then memory returns 32'h00000013 at every address with 3-cycle latency → requests to 0x0, 0x4, 0x8, …; out_pc follows the same sequence with out_jump_flag=0.
- Word 32'h0080006F (JAL +8) at 0x10 → next request is to 0x18; that instruction issues with out_jump_flag=1.
- Word 32'hFE000EE3 (BEQ -4) at 0x20 → next fetch is 0x1C with jump_flag=1. BNE +8 at 0x30 → next fetch 0x34, jump_flag=0.
- in_stall=1 for 20 cycles → queue fills to 8, out_mc_req stays 0, out_inst=0. Release stall → 8 issues in consecutive cycles, in order.
- in_rob_flush with target 0x100 while in WAIT → state DROP, out_mc_req=0, the late done is discarded, next request is to 0x100, queue empty.
- With ICACHE_EN, loop back to 0x0 after first fill → fetch of 0x0 raises no out_mc_req and the word is enqueued in the same cycle.
